load_store_unit: RTL and testbench



---
 rtl/lsu_pkg.sv | 25 ++
 rtl/load_store_unit.sv | 130 +++++++++++++
 tb/tb_load_store_unit.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared types and defaults for the load/store unit: FSM state encoding,
// default data/address widths and the layout of the captured request.
package lsu_pkg;

  localparam int LSU_W = 8;
  localparam int LSU_A = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC0 = 2'd1,
    ACC1 = 2'd2,
    DONE = 2'd3
  } lsu_state_t;

  // Request as latched on the accept edge. Sized by the package defaults,
  // so the unit's W/A parameters are expected to stay at LSU_W/LSU_A.
  typedef struct packed {
    logic                   write;
    logic                   wide;
    logic                   signed_ld;
    logic [LSU_A-1:0]       addr;
    logic [2*LSU_W-1:0]     wdata;
  } lsu_req_t;

endpackage

// File: rtl/load_store_unit.sv
// Load/store unit between the execute stage and an 8-bit single-port data
// memory. One byte or halfword request is accepted in IDLE, split into one
// or two little-endian byte accesses, and answered with a one-cycle response.
// Memory-side outputs are decoded purely from registered state, so an
// asynchronous reset drops MemWriteEn immediately.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int W = LSU_W,
  parameter int A = LSU_A
) (
  input  logic           Clk,
  input  logic           ResetN,
  input  logic           ReqValid,
  output logic           ReqReady,
  input  logic           ReqWrite,
  input  logic           ReqWide,
  input  logic           ReqSigned,
  input  logic [A-1:0]   ReqAddr,
  input  logic [2*W-1:0] ReqWData,
  output logic           RespValid,
  output logic [2*W-1:0] RespRData,
  output logic           MemWriteEn,
  output logic [A-1:0]   MemAddress,
  output logic [W-1:0]   MemDataIn,
  input  logic [W-1:0]   MemDataOut
);

  lsu_state_t     state_q, state_d;
  lsu_req_t       req_q, req_d;
  logic [2*W-1:0] rdata_q, rdata_d;
  logic [A-1:0]   addrHi;

  // The high byte of a halfword lives at the next address, wrapping at the top.
  assign addrHi = req_q.addr + A'(1);

  // Next-state, request capture and load-data collection.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (ReqValid) begin
          req_d.write     = ReqWrite;
          req_d.wide      = ReqWide;
          req_d.signed_ld = ReqSigned;
          req_d.addr      = ReqAddr;
          req_d.wdata     = ReqWData;
          rdata_d         = '0;
          state_d         = ACC0;
        end
      end
      ACC0: begin
        if (!req_q.write) begin
          rdata_d[W-1:0] = MemDataOut;
        end
        state_d = req_q.wide ? ACC1 : DONE;
      end
      ACC1: begin
        if (!req_q.write) begin
          rdata_d[2*W-1:W] = MemDataOut;
        end
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and captured registers, cleared asynchronously.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      state_q <= IDLE;
      req_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      rdata_q <= rdata_d;
    end
  end

  // Memory strobes, handshake and response decoded from the registered state.
  always_comb begin
    ReqReady   = 1'b0;
    RespValid  = 1'b0;
    RespRData  = '0;
    MemWriteEn = 1'b0;
    MemAddress = '0;
    MemDataIn  = '0;
    case (state_q)
      IDLE: begin
        ReqReady = 1'b1;
      end
      ACC0: begin
        MemAddress = req_q.addr;
        if (req_q.write) begin
          MemWriteEn = 1'b1;
          MemDataIn  = req_q.wdata[W-1:0];
        end
      end
      ACC1: begin
        MemAddress = addrHi;
        if (req_q.write) begin
          MemWriteEn = 1'b1;
          MemDataIn  = req_q.wdata[2*W-1:W];
        end
      end
      DONE: begin
        RespValid = 1'b1;
        if (!req_q.write) begin
          if (req_q.wide) begin
            RespRData = rdata_q;
          end else begin
            RespRData = {{W{req_q.signed_ld & rdata_q[W-1]}}, rdata_q[W-1:0]};
          end
        end
      end
      default: begin
        ReqReady = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a table of byte/halfword transactions
// against a behavioural 256-byte memory, plus hand sequences for a held
// request and a reset that lands in the middle of a halfword store.
module tb_load_store_unit;

  logic        Clk;
  logic        ResetN;
  logic        ReqValid;
  logic        ReqReady;
  logic        ReqWrite;
  logic        ReqWide;
  logic        ReqSigned;
  logic [7:0]  ReqAddr;
  logic [15:0] ReqWData;
  logic        RespValid;
  logic [15:0] RespRData;
  logic        MemWriteEn;
  logic [7:0]  MemAddress;
  logic [7:0]  MemDataIn;
  logic [7:0]  MemDataOut;

  logic [7:0]  mem [0:255];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        write;
    logic        wide;
    logic        sgn;
    logic [7:0]  addr;
    logic [15:0] wdata;
    logic [15:0] expRData;
  } vec_t;

  vec_t vecs [15];

  load_store_unit dut (
    .Clk        (Clk),
    .ResetN     (ResetN),
    .ReqValid   (ReqValid),
    .ReqReady   (ReqReady),
    .ReqWrite   (ReqWrite),
    .ReqWide    (ReqWide),
    .ReqSigned  (ReqSigned),
    .ReqAddr    (ReqAddr),
    .ReqWData   (ReqWData),
    .RespValid  (RespValid),
    .RespRData  (RespRData),
    .MemWriteEn (MemWriteEn),
    .MemAddress (MemAddress),
    .MemDataIn  (MemDataIn),
    .MemDataOut (MemDataOut)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Single-port memory: combinational read, write on the rising edge.
  assign MemDataOut = mem[MemAddress];
  always @(posedge Clk) begin
    if (MemWriteEn) mem[MemAddress] <= MemDataIn;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Run one request from the table and check handshake, memory strobes,
  // latency and response data.
  task automatic applyStimulus(input vec_t v);
    int         lat;
    logic [7:0] a0, a1, d0, d1;
    logic       we0, we1;
    @(negedge Clk);
    checkOutput("ready_before_req", ReqReady, 1);
    ReqValid  = 1'b1;
    ReqWrite  = v.write;
    ReqWide   = v.wide;
    ReqSigned = v.sgn;
    ReqAddr   = v.addr;
    ReqWData  = v.wdata;
    @(negedge Clk);
    ReqValid = 1'b0;
    lat = 1;
    a0 = MemAddress; we0 = MemWriteEn; d0 = MemDataIn;
    a1 = 8'h00; we1 = 1'b0; d1 = 8'h00;
    while (!RespValid && lat < 8) begin
      @(negedge Clk);
      lat++;
      if (lat == 2) begin
        a1 = MemAddress; we1 = MemWriteEn; d1 = MemDataIn;
      end
    end
    checkOutput("latency", lat, v.wide ? 3 : 2);
    checkOutput("resp_rdata", RespRData, v.expRData);
    checkOutput("acc0_addr", a0, v.addr);
    checkOutput("acc0_we", we0, v.write);
    if (v.write) checkOutput("acc0_din", d0, v.wdata[7:0]);
    if (v.wide) begin
      checkOutput("acc1_addr", a1, 8'(v.addr + 8'd1));
      checkOutput("acc1_we", we1, v.write);
      if (v.write) checkOutput("acc1_din", d1, v.wdata[15:8]);
    end
    @(negedge Clk);
    checkOutput("resp_single_pulse", RespValid, 0);
  endtask

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got running expected finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int acc, resp;
    int acceptAt [2];
    logic [9:0] readyBits;
    logic [15:0] respData [2];

    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h05] = 8'h80;
    mem[8'h30] = 8'h01;
    mem[8'h31] = 8'h80;
    mem[8'h41] = 8'h77;

    vecs[0]  = '{1'b1, 1'b0, 1'b0, 8'h10, 16'h003C, 16'h0000};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 8'h10, 16'h0000, 16'h003C};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 8'h20, 16'hBEEF, 16'h0000};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 8'h20, 16'h0000, 16'hBEEF};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 8'hFF, 16'h1234, 16'h0000};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 8'hFF, 16'h0000, 16'h1234};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 8'h05, 16'h0000, 16'hFF80};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 8'h05, 16'h0000, 16'h0080};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 8'h30, 16'h0000, 16'h8001};
    vecs[9]  = '{1'b1, 1'b0, 1'b1, 8'h50, 16'hA55A, 16'h0000};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 8'h50, 16'h0000, 16'h005A};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 8'h50, 16'h0000, 16'h005A};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 8'h21, 16'h0000, 16'h00BE};
    vecs[13] = '{1'b0, 1'b0, 1'b1, 8'h21, 16'h0000, 16'hFFBE};
    vecs[14] = '{1'b0, 1'b0, 1'b1, 8'h00, 16'h0000, 16'h0012};

    ResetN = 1'b0; ReqValid = 1'b0; ReqWrite = 1'b0; ReqWide = 1'b0;
    ReqSigned = 1'b0; ReqAddr = 8'h00; ReqWData = 16'h0000;

    #3;
    checkOutput("rst_ready", ReqReady, 1);
    checkOutput("rst_respvalid", RespValid, 0);
    checkOutput("rst_rdata", RespRData, 0);
    checkOutput("rst_we", MemWriteEn, 0);
    checkOutput("rst_addr", MemAddress, 0);
    checkOutput("rst_din", MemDataIn, 0);
    repeat (2) @(negedge Clk);
    ResetN = 1'b1;

    for (int i = 0; i < 15; i++) applyStimulus(vecs[i]);

    checkOutput("mem_10", mem[8'h10], 8'h3C);
    checkOutput("mem_20", mem[8'h20], 8'hEF);
    checkOutput("mem_21", mem[8'h21], 8'hBE);
    checkOutput("mem_ff", mem[8'hFF], 8'h34);
    checkOutput("mem_00", mem[8'h00], 8'h12);
    checkOutput("mem_50", mem[8'h50], 8'h5A);
    checkOutput("mem_51_untouched", mem[8'h51], 8'h00);

    // Held request: a byte load from 0x10 kept valid across two full transactions.
    @(negedge Clk);
    ReqWrite = 1'b0; ReqWide = 1'b0; ReqSigned = 1'b0; ReqAddr = 8'h10;
    ReqValid = 1'b1;
    acc = 0; resp = 0; readyBits = '0;
    acceptAt[0] = -1; acceptAt[1] = -1;
    respData[0] = 16'hFFFF; respData[1] = 16'hFFFF;
    for (int i = 0; i < 10; i++) begin
      if (i == 6) ReqValid = 1'b0;
      readyBits[i] = ReqReady;
      if (ReqReady && ReqValid) begin
        if (acc < 2) acceptAt[acc] = i;
        acc++;
      end
      if (RespValid) begin
        if (resp < 2) respData[resp] = RespRData;
        resp++;
      end
      @(negedge Clk);
    end
    checkOutput("held_accepts", acc, 2);
    checkOutput("held_accept0", acceptAt[0], 0);
    checkOutput("held_accept1", acceptAt[1], 3);
    checkOutput("held_busy1", readyBits[1], 0);
    checkOutput("held_busy2", readyBits[2], 0);
    checkOutput("held_resps", resp, 2);
    checkOutput("held_rdata0", respData[0], 16'h003C);
    checkOutput("held_rdata1", respData[1], 16'h003C);

    // Reset landing in ACC1 of a halfword store 0xAABB to 0x40.
    @(negedge Clk);
    ReqWrite = 1'b1; ReqWide = 1'b1; ReqSigned = 1'b0;
    ReqAddr = 8'h40; ReqWData = 16'hAABB; ReqValid = 1'b1;
    @(negedge Clk);
    ReqValid = 1'b0;
    checkOutput("rstmid_acc0_we", MemWriteEn, 1);
    @(posedge Clk);
    #2;
    checkOutput("rstmid_acc1_we", MemWriteEn, 1);
    checkOutput("rstmid_acc1_addr", MemAddress, 8'h41);
    ResetN = 1'b0;
    #1;
    checkOutput("rstmid_we_drop", MemWriteEn, 0);
    checkOutput("rstmid_addr_clear", MemAddress, 0);
    checkOutput("rstmid_ready", ReqReady, 1);
    resp = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge Clk);
      if (i == 2) ResetN = 1'b1;
      if (RespValid) resp++;
    end
    checkOutput("rstmid_no_resp", resp, 0);
    checkOutput("rstmid_mem_40", mem[8'h40], 8'hBB);
    checkOutput("rstmid_mem_41", mem[8'h41], 8'h77);
    checkOutput("rstmid_ready_after", ReqReady, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
